// File: rtl/sad_block_accum.sv
// Three-stage horizontal sub-pel SAD engine: per-row candidate costs, block
// accumulation over ROWS rows, then a held result with best-candidate select.
module sad_block_accum #(
   parameter int NPIX  = 8,
   parameter int PIX_W = 8,
   parameter int ROWS  = 8,
   parameter int ACC_W = PIX_W + $clog2((NPIX-2)*ROWS+1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_clear,
   input  logic [NPIX*PIX_W-1:0] filt_pix,
   input  logic [NPIX*PIX_W-1:0] ref_pix,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [5*ACC_W-1:0]    sad,
   output logic [2:0]            best_idx,
   output logic [ACC_W-1:0]      best_sad
);

   localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int EXT_W = PIX_W + 2;

   typedef enum logic [2:0] {
      C_RQ = 3'd0,
      C_RH = 3'd1,
      C_F  = 3'd2,
      C_LH = 3'd3,
      C_LQ = 3'd4
   } cand_e;

   logic             w_stall;
   logic             w_accept;

   logic [EXT_W-1:0] w_fl, w_fc, w_fr, w_tmp;
   logic [PIX_W-1:0] w_rp, w_diff;
   logic [PIX_W-1:0] w_cand    [5];
   logic [ACC_W-1:0] w_row_sum [5];

   logic             r_s1_valid;
   logic [ACC_W-1:0] r_s1_sum  [5];

   logic             r_s2_done;
   logic [CNT_W-1:0] r_cnt;
   logic [ACC_W-1:0] r_acc     [5];

   logic             r_out_valid;
   logic [5*ACC_W-1:0] r_sad;
   logic [2:0]       r_best_idx;
   logic [ACC_W-1:0] r_best_sad;

   logic [2:0]       w_best_idx;
   logic [ACC_W-1:0] w_best_sad;

   assign w_stall   = r_out_valid && !out_ready;
   assign in_ready  = !w_stall && !in_clear;
   assign w_accept  = in_valid && in_ready;

   assign out_valid = r_out_valid;
   assign sad       = r_sad;
   assign best_idx  = r_best_idx;
   assign best_sad  = r_best_sad;

   // Candidates are formed at PIX_W+2 bits so the floor is taken on the exact sum.
   always_comb begin
      w_fl   = '0;
      w_fc   = '0;
      w_fr   = '0;
      w_tmp  = '0;
      w_rp   = '0;
      w_diff = '0;
      for (int unsigned k = 0; k < 5; k++) begin
         w_cand[k]    = '0;
         w_row_sum[k] = '0;
      end
      for (int unsigned i = 1; i < NPIX-1; i++) begin
         w_fl = EXT_W'(filt_pix[(i-1)*PIX_W +: PIX_W]);
         w_fc = EXT_W'(filt_pix[i*PIX_W +: PIX_W]);
         w_fr = EXT_W'(filt_pix[(i+1)*PIX_W +: PIX_W]);
         w_rp = ref_pix[i*PIX_W +: PIX_W];

         w_cand[C_F] = w_fc[PIX_W-1:0];
         w_tmp = (w_fl + w_fc) >> 1;
         w_cand[C_LH] = w_tmp[PIX_W-1:0];
         w_tmp = (w_fc + w_fr) >> 1;
         w_cand[C_RH] = w_tmp[PIX_W-1:0];
         w_tmp = (w_fl + w_fc + (w_fc << 1)) >> 2;
         w_cand[C_LQ] = w_tmp[PIX_W-1:0];
         w_tmp = (w_fr + w_fc + (w_fc << 1)) >> 2;
         w_cand[C_RQ] = w_tmp[PIX_W-1:0];

         for (int unsigned k = 0; k < 5; k++) begin
            w_diff = (w_cand[k] >= w_rp) ? (w_cand[k] - w_rp) : (w_rp - w_cand[k]);
            w_row_sum[k] = w_row_sum[k] + ACC_W'(w_diff);
         end
      end
   end

   // S1: registered row sums
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         for (int unsigned k = 0; k < 5; k++) r_s1_sum[k] <= '0;
      end else if (in_clear) begin
         r_s1_valid <= 1'b0;
      end else if (!w_stall) begin
         r_s1_valid <= w_accept;
         if (w_accept) begin
            for (int unsigned k = 0; k < 5; k++) r_s1_sum[k] <= w_row_sum[k];
         end
      end
   end

   // S2: block accumulation; r_s2_done flags that r_acc holds a finished block
   always_ff @(posedge clk) begin
      if (!rst_n || in_clear) begin
         r_s2_done <= 1'b0;
         r_cnt     <= '0;
         for (int unsigned k = 0; k < 5; k++) r_acc[k] <= '0;
      end else if (!w_stall) begin
         r_s2_done <= r_s1_valid && (r_cnt == CNT_W'(ROWS-1));
         if (r_s1_valid) begin
            for (int unsigned k = 0; k < 5; k++) begin
               r_acc[k] <= (r_cnt == '0) ? r_s1_sum[k] : (r_acc[k] + r_s1_sum[k]);
            end
            r_cnt <= (r_cnt == CNT_W'(ROWS-1)) ? '0 : (r_cnt + 1'b1);
         end
      end
   end

   // Strict less-than in priority order makes the earlier candidate win ties.
   always_comb begin
      w_best_idx = C_F;
      w_best_sad = r_acc[C_F];
      if (r_acc[C_RH] < w_best_sad) begin
         w_best_idx = C_RH;
         w_best_sad = r_acc[C_RH];
      end
      if (r_acc[C_LH] < w_best_sad) begin
         w_best_idx = C_LH;
         w_best_sad = r_acc[C_LH];
      end
      if (r_acc[C_RQ] < w_best_sad) begin
         w_best_idx = C_RQ;
         w_best_sad = r_acc[C_RQ];
      end
      if (r_acc[C_LQ] < w_best_sad) begin
         w_best_idx = C_LQ;
         w_best_sad = r_acc[C_LQ];
      end
   end

   // S3: outside a stall the slot is empty or being taken, so it reloads freely
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_sad       <= '0;
         r_best_idx  <= '0;
         r_best_sad  <= '0;
      end else if (!w_stall) begin
         r_out_valid <= r_s2_done;
         if (r_s2_done) begin
            for (int unsigned k = 0; k < 5; k++) r_sad[k*ACC_W +: ACC_W] <= r_acc[k];
            r_best_idx <= w_best_idx;
            r_best_sad <= w_best_sad;
         end
      end
   end

endmodule

// File: tb/tb_sad_block_accum.sv
// Scoreboard bench for sad_block_accum: expected block results are queued when
// a block's last row is accepted and compared whenever the DUT presents one.
module tb_sad_block_accum;

   localparam int NPIX  = 8;
   localparam int PIX_W = 8;
   localparam int ROWS  = 8;
   localparam int ACC_W = PIX_W + $clog2((NPIX-2)*ROWS+1);

   typedef struct {
      logic [5*ACC_W-1:0] sad;
      logic [2:0]         idx;
      logic [ACC_W-1:0]   best;
      int                 due;
   } exp_t;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic                  in_valid = 1'b0;
   logic                  in_ready;
   logic                  in_clear = 1'b0;
   logic [NPIX*PIX_W-1:0] filt_pix = '0;
   logic [NPIX*PIX_W-1:0] ref_pix = '0;
   logic                  out_valid;
   logic                  out_ready = 1'b1;
   logic [5*ACC_W-1:0]    sad;
   logic [2:0]            best_idx;
   logic [ACC_W-1:0]      best_sad;

   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   exp_t sb[$];
   logic prev_ov = 1'b0;
   exp_t e_const, e_ramp, e_max, e_none;

   sad_block_accum #(.NPIX(NPIX), .PIX_W(PIX_W), .ROWS(ROWS)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_clear(in_clear), .filt_pix(filt_pix), .ref_pix(ref_pix),
      .out_valid(out_valid), .out_ready(out_ready), .sad(sad),
      .best_idx(best_idx), .best_sad(best_sad)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Result monitor: every presented cycle is checked against the queue head,
   // which also covers output stability while the consumer stalls.
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_result: out_valid=1 with nothing expected, sad=%h", sad);
         end else begin
            if (sad !== sb[0].sad || best_idx !== sb[0].idx || best_sad !== sb[0].best) begin
               n_fail++;
               $display("FAIL block_result: got sad=%h idx=%0d best=%0d, expected sad=%h idx=%0d best=%0d",
                        sad, best_idx, best_sad, sb[0].sad, sb[0].idx, sb[0].best);
            end
            if (!prev_ov && sb[0].due >= 0) begin
               n_checks++;
               if (cyc !== sb[0].due) begin
                  n_fail++;
                  $display("FAIL result_latency: out_valid at cycle %0d, expected cycle %0d", cyc, sb[0].due);
               end
            end
            if (!out_ready) begin
               n_checks++;
               if (in_ready !== 1'b0) begin
                  n_fail++;
                  $display("FAIL stall_in_ready: got %b, expected 0", in_ready);
               end
            end
            if (out_ready) void'(sb.pop_front());
         end
      end
      prev_ov = out_valid & rst_n;
   end

   function automatic exp_t mk(input int lq, lh, f, rh, rq, input int idx, best);
      exp_t e;
      e.sad  = {ACC_W'(lq), ACC_W'(lh), ACC_W'(f), ACC_W'(rh), ACC_W'(rq)};
      e.idx  = 3'(idx);
      e.best = ACC_W'(best);
      e.due  = -1;
      return e;
   endfunction

   task automatic send_row(input logic [NPIX*PIX_W-1:0] f, r, output int acyc);
      int  w;
      bit  rdy;
      in_valid = 1'b1;
      filt_pix = f;
      ref_pix  = r;
      w = 0;
      acyc = -1;
      forever begin
         @(negedge clk);
         rdy  = in_ready;
         acyc = cyc;
         @(posedge clk);
         #1;
         if (rdy) break;
         w++;
         if (w > 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL row_accept_timeout: in_ready stayed 0, expected 1 within 200 cycles");
            break;
         end
      end
   endtask

   // kind 0: constant rows a/b, 1: ramp f=16i r=16i+8, 2: random rows scored by the model
   task automatic send_block(input int kind, input logic [7:0] a, b, input int nrows,
                             input bit push, input exp_t ex);
      logic [NPIX*PIX_W-1:0] f, r;
      int   c[5];
      int   acyc, fl, fc, fr, rp, cand[5], d;
      exp_t e;
      for (int k = 0; k < 5; k++) c[k] = 0;
      acyc = 0;
      for (int row = 0; row < nrows; row++) begin
         for (int i = 0; i < NPIX; i++) begin
            case (kind)
               0:       begin f[i*8 +: 8] = a;              r[i*8 +: 8] = b; end
               1:       begin f[i*8 +: 8] = 8'(16*i);       r[i*8 +: 8] = 8'(16*i + 8); end
               default: begin f[i*8 +: 8] = 8'($urandom);   r[i*8 +: 8] = 8'($urandom); end
            endcase
         end
         for (int i = 1; i < NPIX-1; i++) begin
            fl = int'(f[(i-1)*8 +: 8]);
            fc = int'(f[i*8 +: 8]);
            fr = int'(f[(i+1)*8 +: 8]);
            rp = int'(r[i*8 +: 8]);
            cand[0] = (3*fc + fr) / 4;
            cand[1] = (fc + fr) / 2;
            cand[2] = fc;
            cand[3] = (fl + fc) / 2;
            cand[4] = (fl + 3*fc) / 4;
            for (int k = 0; k < 5; k++) begin
               d = cand[k] - rp;
               c[k] += (d < 0) ? -d : d;
            end
         end
         send_row(f, r, acyc);
      end
      in_valid = 1'b0;
      if (push) begin
         if (kind == 2) begin
            int order[5] = '{2, 1, 3, 0, 4};
            int bi = 2;
            for (int j = 1; j < 5; j++) if (c[order[j]] < c[bi]) bi = order[j];
            e = mk(c[4], c[3], c[2], c[1], c[0], bi, c[bi]);
         end else begin
            e = ex;
         end
         e.due = acyc + 3;
         sb.push_back(e);
      end
   endtask

   task automatic wait_drain();
      int w = 0;
      while (sb.size() != 0 && w < 80) begin
         @(posedge clk);
         #1;
         w++;
      end
      if (sb.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic wait_out_valid(input string tag);
      int w = 0;
      while (out_valid !== 1'b1 && w < 60) begin
         @(posedge clk);
         #1;
         w++;
      end
      if (out_valid !== 1'b1) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_wait: out_valid=%b, expected 1 within 60 cycles", tag, out_valid);
      end
   endtask

   task automatic check_idle(input string tag);
      @(negedge clk);
      n_checks += 5;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL %s_out_valid: got %b, expected 0", tag, out_valid); end
      if (sad !== '0)         begin n_fail++; $display("FAIL %s_sad: got %h, expected 0", tag, sad); end
      if (best_idx !== 3'd0)  begin n_fail++; $display("FAIL %s_best_idx: got %0d, expected 0", tag, best_idx); end
      if (best_sad !== '0)    begin n_fail++; $display("FAIL %s_best_sad: got %0d, expected 0", tag, best_sad); end
      if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL %s_in_ready: got %b, expected 1", tag, in_ready); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      check_idle("reset");
   endtask

   task automatic test_patterns();
      send_block(0, 8'd100, 8'd110, ROWS, 1'b1, e_const);
      wait_drain();
      send_block(1, 8'd0, 8'd0, ROWS, 1'b1, e_ramp);
      wait_drain();
      send_block(0, 8'd255, 8'd0, ROWS, 1'b1, e_max);
      wait_drain();
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b0;
      fork
         begin
            send_block(0, 8'd100, 8'd110, ROWS, 1'b1, e_const);
            send_block(1, 8'd0, 8'd0, ROWS, 1'b1, e_ramp);
         end
         begin
            wait_out_valid("stall");
            repeat (5) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      wait_drain();
   endtask

   task automatic test_random_backpressure();
      bit done = 1'b0;
      fork
         begin
            for (int blk = 0; blk < 3; blk++) send_block(2, 8'd0, 8'd0, ROWS, 1'b1, e_none);
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1 out_ready = 1'($urandom_range(0, 1));
            end
            out_ready = 1'b1;
         end
      join
      wait_drain();
   endtask

   task automatic test_clear();
      send_block(0, 8'd255, 8'd0, 3, 1'b0, e_none);
      in_clear = 1'b1;
      fork
         begin
            @(negedge clk);
            n_checks++;
            if (in_ready !== 1'b0) begin
               n_fail++;
               $display("FAIL clear_in_ready: got %b, expected 0", in_ready);
            end
            @(posedge clk);
            #1 in_clear = 1'b0;
         end
         send_block(1, 8'd0, 8'd0, ROWS, 1'b1, e_ramp);
      join
      wait_drain();
   endtask

   task automatic test_reset_mid();
      send_block(0, 8'd255, 8'd0, 4, 1'b0, e_none);
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      check_idle("rst_midblock");
      out_ready = 1'b0;
      send_block(0, 8'd255, 8'd0, ROWS, 1'b1, e_max);
      wait_out_valid("rst_stall");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      sb.delete();
      out_ready = 1'b1;
      check_idle("rst_midstall");
      send_block(1, 8'd0, 8'd0, ROWS, 1'b1, e_ramp);
      wait_drain();
   endtask

   initial begin
      e_none  = mk(0, 0, 0, 0, 0, 0, 0);
      e_const = mk(480, 480, 480, 480, 480, 2, 480);
      e_ramp  = mk(576, 768, 384, 0, 192, 1, 0);
      e_max   = mk(12240, 12240, 12240, 12240, 12240, 2, 12240);
      test_reset();
      test_patterns();
      test_back_to_back();
      test_random_backpressure();
      test_clear();
      test_reset_mid();
      repeat (5) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
